// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver: 2-FF input synchroniser, bit-timing FSM and a
// first-word-fall-through byte FIFO with sticky overrun / framing flags.
module uart_rx_buffer #(
   parameter int CLKS_PER_BIT = 27,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rxd,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   output logic                          frame_err,
   input  logic                          err_clr
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    idx, idx_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          push_q, push_nx;
   logic          ferr_q, ferr_nx;
   logic          sync1, rxs;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop, wr_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         shreg  <= '0;
         push_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         idx    <= idx_nx;
         shreg  <= shreg_nx;
         push_q <= push_nx;
         ferr_q <= ferr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      idx_nx   = idx;
      shreg_nx = shreg;
      push_nx  = 1'b0;
      ferr_nx  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (!rxs) state_nx = START;
         end
         START: if (cnt == HALF_M1) begin
            // mid-start-bit check rejects glitches shorter than half a bit
            cnt_nx   = '0;
            idx_nx   = '0;
            state_nx = rxs ? IDLE : DATA;
         end
         DATA: if (cnt == FULL_M1) begin
            cnt_nx   = '0;
            shreg_nx = {rxs, shreg[7:1]};
            idx_nx   = idx + 1'b1;
            if (idx == 3'd7) state_nx = STOP;
         end
         STOP: if (cnt == FULL_M1) begin
            cnt_nx   = '0;
            push_nx  = rxs;
            ferr_nx  = !rxs;
            state_nx = rxs ? IDLE : WAIT_HIGH;
         end
         WAIT_HIGH: begin
            cnt_nx = '0;
            if (rxs) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // shreg holds still in IDLE, so the push one cycle after the stop sample is safe
   assign pop      = rx_valid && rx_ready;
   assign wr_en    = push_q && ((fifo_count < DEPTH) || pop);
   assign rx_valid = (fifo_count != '0);
   assign rx_data  = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // a new error event takes priority over a coincident clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (push_q && !wr_en) overrun <= 1'b1;
         else if (err_clr)     overrun <= 1'b0;
         if (ferr_q)           frame_err <= 1'b1;
         else if (err_clr)     frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer at 4 clocks per bit, FIFO depth 8.
module tb_uart_rx_buffer;
   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rxd = 1'b1;
   logic       rx_ready = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [3:0] fifo_count;
   logic       overrun, frame_err;

   int n_chk = 0;
   int n_err = 0;
   logic [7:0] sb [$];

   uart_rx_buffer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .rxd(rxd), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_count(fifo_count),
      .overrun(overrun), .frame_err(frame_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // every accepted handshake must match the oldest expected byte
   always @(negedge clk) begin
      if (!reset && rx_valid && rx_ready) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got %0h expected none", rx_data);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (rx_data !== e) begin
               n_err++;
               $display("FAIL pop_data: got %0h expected %0h", rx_data, e);
            end
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // starts just after a rising edge, returns just after the edge ending the stop bit
   task automatic send(logic [7:0] b, logic stop_bit = 1'b1);
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(CPB);
      end
      rxd = stop_bit;
      tick(CPB);
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      tick(12);
      rx_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] v;
      tick(3);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_count", fifo_count, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_frame_err", frame_err, 0);
      reset = 1'b0;
      tick(3);

      // single byte, checking push latency
      sb.push_back(8'hA5);
      send(8'hA5);
      tick(1);
      chk("lat_not_yet", rx_valid, 0);
      tick(1);
      chk("a5_valid", rx_valid, 1);
      chk("a5_data", rx_data, 8'hA5);
      chk("a5_count", fifo_count, 1);
      chk("a5_flags", {overrun, frame_err}, 0);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      chk("a5_pop_valid", rx_valid, 0);
      chk("a5_pop_count", fifo_count, 0);

      // one-cycle glitch
      rxd = 1'b0;
      tick(1);
      rxd = 1'b1;
      tick(12);
      chk("glitch_count", fifo_count, 0);
      chk("glitch_flags", {overrun, frame_err}, 0);

      // framing error with line held low (break)
      send(8'h3C, 1'b0);
      tick(20);
      chk("ferr_set", frame_err, 1);
      chk("ferr_count", fifo_count, 0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(6);
      chk("ferr_single", frame_err, 0);
      rxd = 1'b1;
      tick(4);
      sb.push_back(8'h11);
      send(8'h11);
      tick(3);
      chk("after_break_count", fifo_count, 1);
      chk("after_break_data", rx_data, 8'h11);
      chk("after_break_ferr", frame_err, 0);
      drain();

      // overrun: 9 bytes into an 8-deep FIFO
      for (int i = 0; i < 9; i++) begin
         v = 8'(i);
         if (i < 8) sb.push_back(v);
         send(v);
         tick(2);
      end
      tick(2);
      chk("ovr_count", fifo_count, 8);
      chk("ovr_flag", overrun, 1);
      chk("ovr_head", rx_data, 8'h00);
      drain();
      chk("ovr_drained", fifo_count, 0);
      chk("ovr_sb_empty", sb.size(), 0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("ovr_clr", overrun, 0);

      // full FIFO with a pop in the same cycle as the push
      for (int i = 0; i < 9; i++) sb.push_back(8'(8'h20 + i));
      for (int i = 0; i < 8; i++) begin
         send(8'(8'h20 + i));
         tick(2);
      end
      chk("full_count", fifo_count, 8);
      send(8'h28);
      tick(1);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(2);
      chk("simul_count", fifo_count, 8);
      chk("simul_overrun", overrun, 0);
      chk("simul_head", rx_data, 8'h21);
      drain();
      chk("simul_sb_empty", sb.size(), 0);

      // reset during data bit 4, with a byte already buffered
      sb.push_back(8'h77);
      send(8'h77);
      tick(4);
      v = 8'h5A;
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rxd = v[i];
         tick(CPB);
      end
      rxd = v[4];
      tick(2);
      reset = 1'b1;
      rxd = 1'b1;
      sb.delete();
      tick(1);
      chk("mid_rst_valid", rx_valid, 0);
      chk("mid_rst_data", rx_data, 8'h00);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_flags", {overrun, frame_err}, 0);
      reset = 1'b0;
      tick(20);
      chk("post_rst_idle", fifo_count, 0);
      sb.push_back(8'h5A);
      send(8'h5A);
      tick(3);
      chk("post_rst_count", fifo_count, 1);
      chk("post_rst_data", rx_data, 8'h5A);
      drain();
      chk("post_rst_sb_empty", sb.size(), 0);
      chk("final_count", fifo_count, 0);
      chk("final_flags", {overrun, frame_err}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
